pool_window_gen: RTL and testbench

Line-buffered 2x2 window generator feeding the max-pool compare stage. It accepts a raster-ordered stream of signed conv-layer outputs and, once per non-overlapping 2x2 window (stride 2), presents the four window pixels as two packed row-pairs with a one-cycle valid strobe. Output ports map directly onto the compare stage inputs `valid`, `x_m_1` and `x_m_2`. No backpressure: the compare stage is fully pipelined and always accepts.

---
 rtl/pool_window_gen.sv | 103 ++++++++++
 tb/tb_pool_window_gen.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pool_window_gen.sv
// pool_window_gen: line-buffered 2x2 / stride-2 window generator for max-pool.
// Takes a raster-ordered signed pixel stream. After the bottom-right pixel of
// each non-overlapping 2x2 window is accepted, it presents the window as two
// packed row pairs, together with a one-cycle valid strobe.
module pool_window_gen #(
  parameter int DW = 22,
  parameter int W  = 24,
  parameter int H  = 24
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            clr_i,
  input  logic            in_valid_i,
  input  logic [DW-1:0]   in_data_i,
  output logic            out_valid_o,
  output logic [2*DW-1:0] x_m_1_o,
  output logic [2*DW-1:0] x_m_2_o,
  output logic            frame_done_o
);

  localparam int CW = (W > 1) ? $clog2(W) : 1;
  localparam int RW = (H > 1) ? $clog2(H) : 1;
  localparam logic [CW-1:0] COL_LAST = CW'(W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(H - 1);

  logic [CW-1:0]   col_q, col_d;
  logic [RW-1:0]   row_q, row_d;
  logic [DW-1:0]   bl_q, bl_d;
  logic            vld_q, vld_d;
  logic            fd_q, fd_d;
  logic [2*DW-1:0] xm1_q, xm1_d, xm2_q, xm2_d;

  // One entry per column. It holds the most recent even (top) row.
  logic [DW-1:0]   lbuf_q [W];

  logic acc;
  assign acc = in_valid_i && !clr_i;

  // Next state: counters, bottom-left hold, and window emit. clr wins over data.
  always_comb begin
    col_d = col_q;
    row_d = row_q;
    bl_d  = bl_q;
    vld_d = 1'b0;
    fd_d  = 1'b0;
    xm1_d = xm1_q;
    xm2_d = xm2_q;
    if (clr_i) begin
      col_d = '0;
      row_d = '0;
      xm1_d = '0;
      xm2_d = '0;
    end else if (in_valid_i) begin
      if (row_q[0] && !col_q[0]) bl_d = in_data_i;
      if (row_q[0] && col_q[0]) begin
        // Because col is odd here, col-1 is the left column of this window.
        xm1_d = {lbuf_q[col_q - CW'(1)], lbuf_q[col_q]};
        xm2_d = {bl_q, in_data_i};
        vld_d = 1'b1;
        fd_d  = (row_q == ROW_LAST) && (col_q == COL_LAST);
      end
      if (col_q == COL_LAST) begin
        col_d = '0;
        row_d = (row_q == ROW_LAST) ? '0 : row_q + RW'(1);
      end else begin
        col_d = col_q + CW'(1);
      end
    end
  end

  // State and output registers. Every output comes straight from a flop.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      col_q <= '0;
      row_q <= '0;
      bl_q  <= '0;
      vld_q <= 1'b0;
      fd_q  <= 1'b0;
      xm1_q <= '0;
      xm2_q <= '0;
    end else begin
      col_q <= col_d;
      row_q <= row_d;
      bl_q  <= bl_d;
      vld_q <= vld_d;
      fd_q  <= fd_d;
      xm1_q <= xm1_d;
      xm2_q <= xm2_d;
    end
  end

  // The line buffer captures even rows only and is never cleared.
  // The preceding even row always fills a location before anything reads it.
  always_ff @(posedge clk) begin
    if (acc && !row_q[0]) lbuf_q[col_q] <= in_data_i;
  end

  assign out_valid_o  = vld_q;
  assign frame_done_o = fd_q;
  assign x_m_1_o      = xm1_q;
  assign x_m_2_o      = xm2_q;

endmodule

// File: tb/tb_pool_window_gen.sv
// Testbench for pool_window_gen at W=4, H=4, DW=22.
// A frame-level reference model tracks each pixel's (row, col) position and
// predicts every window from a stored copy of the frame.
module tb_pool_window_gen;
  localparam int DW = 22;
  localparam int W  = 4;
  localparam int H  = 4;

  logic            clk = 1'b0;
  logic            rstn = 1'b0;
  logic            clr = 1'b0;
  logic            in_valid = 1'b0;
  logic [DW-1:0]   in_data = '0;
  logic            out_valid;
  logic [2*DW-1:0] x_m_1, x_m_2;
  logic            frame_done;

  int checks = 0;
  int errors = 0;

  pool_window_gen #(.DW(DW), .W(W), .H(H)) dut (
    .clk(clk), .rstn(rstn), .clr_i(clr), .in_valid_i(in_valid),
    .in_data_i(in_data), .out_valid_o(out_valid), .x_m_1_o(x_m_1),
    .x_m_2_o(x_m_2), .frame_done_o(frame_done)
  );

  always #5 clk = ~clk;

  // Reference model state
  logic [DW-1:0]   pix [H][W];
  int              mp;            // pixel index within the current frame
  logic            e_v, e_fd;
  logic [2*DW-1:0] e_m1, e_m2;
  int              n_v, n_fd;     // pulse counters

  task automatic model_reset();
    mp = 0; e_v = 0; e_fd = 0; e_m1 = '0; e_m2 = '0;
  endtask

  // Drive one cycle, wait for the edge, then advance the model to the state
  // expected just after that edge.
  task automatic cyc(input logic v, input logic [DW-1:0] d, input logic c);
    int r, k;
    in_valid = v; in_data = d; clr = c;
    @(posedge clk); #1;
    e_v = 0; e_fd = 0;
    if (c) begin
      mp = 0; e_m1 = '0; e_m2 = '0;
    end else if (v) begin
      r = mp / W; k = mp % W;
      pix[r][k] = d;
      if ((r % 2 == 1) && (k % 2 == 1)) begin
        e_v  = 1;
        e_m1 = {pix[r-1][k-1], pix[r-1][k]};
        e_m2 = {pix[r][k-1], pix[r][k]};
        e_fd = (mp == W*H - 1);
      end
      mp = (mp + 1) % (W*H);
    end
    if (out_valid === 1'b1) n_v++;
    if (frame_done === 1'b1) n_fd++;
  endtask

  task automatic test_reset();
    in_valid = 1; in_data = 22'h12345; clr = 0;
    rstn = 0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (out_valid !== 0 || frame_done !== 0 || x_m_1 !== '0 || x_m_2 !== '0) begin
      errors++;
      $display("FAIL reset: v=%b fd=%b m1=%h m2=%h required all 0", out_valid, frame_done, x_m_1, x_m_2);
    end
    in_valid = 0;
    @(negedge clk); rstn = 1;
    model_reset();
  endtask

  task automatic test_frame_continuous();
    n_v = 0; n_fd = 0;
    for (int i = 0; i < 16; i++) begin
      cyc(1, DW'(i), 0);
      checks++;
      if (out_valid !== e_v || frame_done !== e_fd || x_m_1 !== e_m1 || x_m_2 !== e_m2) begin
        errors++;
        $display("FAIL continuous px%0d: v=%b fd=%b m1=%h m2=%h required v=%b fd=%b m1=%h m2=%h",
                 i, out_valid, frame_done, x_m_1, x_m_2, e_v, e_fd, e_m1, e_m2);
      end
    end
    cyc(0, '0, 0);
    checks++;
    if (n_v != 4 || n_fd != 1) begin
      errors++;
      $display("FAIL continuous_count: pulses=%0d fd=%0d required 4 and 1", n_v, n_fd);
    end
  endtask

  task automatic test_gaps();
    n_v = 0; n_fd = 0;
    for (int i = 0; i < 16; i++) begin
      cyc(1, DW'(i), 0);
      checks++;
      if (out_valid !== e_v || frame_done !== e_fd || x_m_1 !== e_m1 || x_m_2 !== e_m2) begin
        errors++;
        $display("FAIL gaps px%0d: v=%b fd=%b m1=%h m2=%h required v=%b m1=%h m2=%h",
                 i, out_valid, frame_done, x_m_1, x_m_2, e_v, e_m1, e_m2);
      end
      for (int g = 0; g < ((i % W == W-1) ? 5 : 1); g++) begin
        cyc(0, DW'($urandom), 0);
        checks++;
        if (out_valid !== e_v || frame_done !== e_fd || x_m_1 !== e_m1 || x_m_2 !== e_m2) begin
          errors++;
          $display("FAIL gaps idle after px%0d: v=%b fd=%b m1=%h m2=%h required v=%b m1=%h m2=%h",
                   i, out_valid, frame_done, x_m_1, x_m_2, e_v, e_m1, e_m2);
        end
      end
    end
    checks++;
    if (n_v != 4 || n_fd != 1) begin
      errors++;
      $display("FAIL gaps_count: pulses=%0d fd=%0d required 4 and 1", n_v, n_fd);
    end
  endtask

  task automatic test_signed();
    logic [DW-1:0]   d [16];
    logic [2*DW-1:0] t1, t2;
    t1 = {22'h200000, 22'h1FFFFF};
    t2 = {22'h3FFFFF, 22'h000000};
    for (int i = 0; i < 16; i++) d[i] = DW'($urandom);
    d[0] = 22'h200000; d[1] = 22'h1FFFFF; d[4] = 22'h3FFFFF; d[5] = 22'h000000;
    for (int i = 0; i < 16; i++) begin
      cyc(1, d[i], 0);
      checks++;
      if (out_valid !== e_v || frame_done !== e_fd || x_m_1 !== e_m1 || x_m_2 !== e_m2) begin
        errors++;
        $display("FAIL signed px%0d: v=%b m1=%h m2=%h required v=%b m1=%h m2=%h",
                 i, out_valid, x_m_1, x_m_2, e_v, e_m1, e_m2);
      end
      if (i == 5) begin
        checks++;
        if (out_valid !== 1 || x_m_1 !== t1 || x_m_2 !== t2) begin
          errors++;
          $display("FAIL signed_extremes: v=%b m1=%h m2=%h required 1 %h %h", out_valid, x_m_1, x_m_2, t1, t2);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [2*DW-1:0] t1, t2;
    t1 = {22'd100, 22'd101};
    t2 = {22'd104, 22'd105};
    n_v = 0; n_fd = 0;
    for (int i = 0; i < 32; i++) begin
      cyc(1, (i < 16) ? DW'(i) : DW'(100 + i - 16), 0);
      checks++;
      if (out_valid !== e_v || frame_done !== e_fd || x_m_1 !== e_m1 || x_m_2 !== e_m2) begin
        errors++;
        $display("FAIL b2b px%0d: v=%b fd=%b m1=%h m2=%h required v=%b fd=%b m1=%h m2=%h",
                 i, out_valid, frame_done, x_m_1, x_m_2, e_v, e_fd, e_m1, e_m2);
      end
      if (i == 21) begin
        checks++;
        if (out_valid !== 1 || x_m_1 !== t1 || x_m_2 !== t2) begin
          errors++;
          $display("FAIL b2b_second_first: v=%b m1=%h m2=%h required 1 %h %h", out_valid, x_m_1, x_m_2, t1, t2);
        end
      end
    end
    cyc(0, '0, 0);
    checks++;
    if (n_v != 8 || n_fd != 2) begin
      errors++;
      $display("FAIL b2b_count: pulses=%0d fd=%0d required 8 and 2", n_v, n_fd);
    end
  endtask

  // Abort a partial frame with clr (use_rst=0) or with async reset (use_rst=1),
  // then send a clean frame.
  task automatic test_abort(input bit use_rst);
    for (int i = 0; i < 6; i++) cyc(1, DW'($urandom), 0);
    if (use_rst) begin
      in_valid = 1; #2 rstn = 0;
      #1;
      checks++;
      if (out_valid !== 0 || frame_done !== 0 || x_m_1 !== '0 || x_m_2 !== '0) begin
        errors++;
        $display("FAIL async_reset: v=%b m1=%h m2=%h required all 0", out_valid, x_m_1, x_m_2);
      end
      @(negedge clk); rstn = 1; in_valid = 0;
      model_reset();
    end else begin
      cyc(1, DW'($urandom), 1);
      checks++;
      if (out_valid !== 0 || frame_done !== 0 || x_m_1 !== '0 || x_m_2 !== '0) begin
        errors++;
        $display("FAIL clr: v=%b fd=%b m1=%h m2=%h required all 0", out_valid, frame_done, x_m_1, x_m_2);
      end
    end
    n_v = 0; n_fd = 0;
    for (int i = 0; i < 16; i++) begin
      cyc(1, DW'(i), 0);
      checks++;
      if (out_valid !== e_v || frame_done !== e_fd || x_m_1 !== e_m1 || x_m_2 !== e_m2) begin
        errors++;
        $display("FAIL abort%0d px%0d: v=%b fd=%b m1=%h m2=%h required v=%b fd=%b m1=%h m2=%h",
                 use_rst, i, out_valid, frame_done, x_m_1, x_m_2, e_v, e_fd, e_m1, e_m2);
      end
    end
    cyc(0, '0, 0);
    checks++;
    if (n_v != 4 || n_fd != 1) begin
      errors++;
      $display("FAIL abort%0d_count: pulses=%0d fd=%0d required 4 and 1", use_rst, n_v, n_fd);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      cyc($urandom_range(0, 3) != 0, DW'($urandom), $urandom_range(0, 99) == 0);
      checks++;
      if (out_valid !== e_v || frame_done !== e_fd || x_m_1 !== e_m1 || x_m_2 !== e_m2) begin
        errors++;
        $display("FAIL random cyc%0d: v=%b fd=%b m1=%h m2=%h required v=%b fd=%b m1=%h m2=%h",
                 i, out_valid, frame_done, x_m_1, x_m_2, e_v, e_fd, e_m1, e_m2);
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_frame_continuous();
    test_gaps();
    test_signed();
    test_back_to_back();
    test_abort(0);
    test_abort(1);
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
